// File: rtl/key_cond_pkg.sv
// Shared definitions for the push-button conditioning block: channel FSM
// encoding and debounce interval constants.
package key_cond_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CNT_P = 2'd1,
        PRS   = 2'd2,
        CNT_R = 2'd3
    } key_state_e;

    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 8;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchronizer, debounce FSM with qualification counter,
// registered level, press/release strobes and press toggle.
//
// state | meaning
// REL   | debounced released, waiting for s = 1
// CNT_P | s = 1 seen, counting consecutive pressed samples
// PRS   | debounced pressed, waiting for s = 0
// CNT_R | s = 0 seen, counting consecutive released samples
module key_debounce_channel
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;

    assign s = ~sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            REL: begin
                if (s) begin
                    state_d = CNT_P;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            CNT_P: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRS: begin
                if (!s) begin
                    state_d = CNT_R;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            CNT_R: begin
                if (s) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the FSM edge.
    always_comb begin
        level_d   = (state_d == PRS) || (state_d == CNT_R);
        press_d   = (state_q == CNT_P) && (state_d == PRS);
        release_d = (state_q == CNT_R) && (state_d == REL);
        toggle_d  = toggle_q ^ press_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            state_q   <= REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_toggle  = toggle_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: N_KEYS independent synchronize/debounce channels
// producing clean level, press/release strobes and toggle per key.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_n      (key_n[g]),
            .key_level  (key_level[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g]),
            .key_toggle (key_toggle[g])
        );
    end

endmodule
